grf_writeback_arbiter: RTL and testbench
========================================

// Module: grf_writeback_arbiter
// PURPOSE
// - Sole writer of the GRF write port (WriteEnabled/A3/WriteData/PC4).
// - Merges two sources: pipeline W-stage writeback (port P, never back-pressured)
//   and late-result writeback (port S: MDU/multi-cycle units, valid/ready).
// - S requests wait in a FIFO and drain on cycles where P does not write.
// - Exports a pending-register mask so the hazard unit can stall readers of queued registers.
// PARAMETERS
// DEPTH        4   S-queue entries (power of 2, >=2)
// STARVE_LIMIT 8   consecutive blocked cycles before p_stall is raised (>=1)
// PORTS
// Clk          in   1   clock; all state updates on posedge
// Reset        in   1   synchronous, active-high
// p_we         in   1   pipeline writeback request
// p_addr       in   5   pipeline dest register
// p_data       in   32  pipeline write data
// p_pc4        in   32  PC+4 of writing instruction
// s_valid      in   1   late-result request
// s_ready      out  1   S-queue can accept
// s_addr       in   5   late-result dest register
// s_data       in   32  late-result data
// s_pc4        in   32  PC+4 of originating instruction
// grf_we       out  1   to GRF WriteEnabled
// grf_a3       out  5   to GRF A3
// grf_wd       out  32  to GRF WriteData
// grf_pc4      out  32  to GRF PC4
// pending      out  32  bit r set = valid queued entry targets $r (bit 0 always 0)
// q_count      out  clog2(DEPTH)+1  queued entry count
// p_stall      out  1   registered; asks pipeline to insert a W-stage bubble
// BEHAVIOUR
// - Reset: queue emptied, q_count=0, pending=0, p_stall=0, starve counter=0;
//   grf_we=0 and s_ready=0 while Reset high. Reset mid-drain discards all entries.
// - grf_* combinational, zero latency; GRF commits at same posedge.
// - P active when p_we && p_addr!=0: grf_*=P fields; P always wins, never dropped or delayed.
// - Else, if queue non-empty: grf_*=head fields, grf_we=1, head popped at posedge.
// - Else grf_we=0; grf_a3/wd/pc4 = 0.
// - s_ready = !Reset && q_count<DEPTH, from registered count only; a pop in the
//   same cycle does not open a slot when full.
// - Accept = s_valid && s_ready. s_addr==0 accepted but not enqueued (no pending,
//   no count change). Otherwise enqueue at tail.
// - Push and pop in the same cycle: both happen, count unchanged.
// - Empty queue + accepted S + no P: not bypassed; entry written the next free
//   cycle, so write latency is >=1 cycle.
// - WAW kill: P active to $r clears valid on every queued entry with addr r
//   (P is younger). Killed entries still occupy slots and are skipped at head:
//   popped with grf_we=0, or combinationally skipped; no GRF write for killed entry.
//   q_count counts occupied slots; pending counts valid entries only.
// - S entries drain in FIFO order. Two entries for the same $r both write, in order.
// - Starve counter: increments each cycle a valid head is blocked by P; clears on pop or empty.
//   p_stall<=1 when counter reaches STARVE_LIMIT-1 and head still blocked.
//   Drops the cycle after the head pops.
//   If P writes while p_stall=1, P still wins (protocol error, no drop).
// - pending[r] updates on posedge: set on enqueue, cleared on pop or kill.
// TESTING
// - Reset, then s: $5=0x11 (pc4 0x3004), no P -> next cycle grf_we=1 a3=5 wd=0x11
//   pc4=0x3004; pending[5] 1->0.
// - P to $3=0xAA same cycle as queued head $7 -> grf_a3=3 that cycle, $7 written next cycle.
// - Fill DEPTH=4 with $1..$4 while P writes every cycle -> s_ready=0 on 5th, q_count=4;
//   p_stall=1 after 8 blocked cycles; bubble drains $1 first.
// - Queue $9=0x1, then P writes $9=0x2 -> pending[9]=0; GRF $9 ends 0x2, killed entry never written.
// - S with s_addr=0 -> s_ready=1, q_count unchanged, grf_we never 1 for it.
// - Assert Reset with 3 entries queued -> next cycle q_count=0, pending=0, grf_we=0, no stale writes.

Source files
------------

// File: rtl/grf_writeback_arbiter.sv
// grf_writeback_arbiter
//   Sole writer of the GRF write port. Merges two writeback sources:
//     P: pipeline W-stage writeback. It is never back-pressured and always wins.
//     S: late results from multi-cycle units. They use a valid/ready handshake and
//        are queued in a FIFO. The FIFO drains on cycles where P does not write.
//   Exports a pending-register mask so the hazard unit can stall readers of queued
//   registers. Raises p_stall to request a W-stage bubble when the queue head starves.
//
// Ports
//   Clk, Reset              clock; synchronous active-high reset
//   p_we/p_addr/p_data/p_pc4 pipeline writeback request
//   s_valid/s_ready          late-result handshake
//   s_addr/s_data/s_pc4      late-result payload
//   grf_we/a3/wd/pc4         GRF write port (combinational, commits at the same posedge)
//   pending                  bit r set = a valid queued entry targets $r
//   q_count                  occupied queue slots (killed entries included)
//   p_stall                  registered bubble request to the pipeline
module grf_writeback_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     p_we,
    input  logic [4:0]               p_addr,
    input  logic [31:0]              p_data,
    input  logic [31:0]              p_pc4,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [4:0]               s_addr,
    input  logic [31:0]              s_data,
    input  logic [31:0]              s_pc4,
    output logic                     grf_we,
    output logic [4:0]               grf_a3,
    output logic [31:0]              grf_wd,
    output logic [31:0]              grf_pc4,
    output logic [31:0]              pending,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     p_stall
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT) + 1;

    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      pc4_q  [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [AW-1:0]    head_q;
    logic [AW-1:0]    tail_q;
    logic [CW-1:0]    count_q;
    logic [SW-1:0]    starve_q;
    logic             p_stall_q;

    logic p_active;
    logic q_empty;
    logic head_valid;
    logic head_blocked;
    logic pop;
    logic push;

    assign p_active     = p_we && (p_addr != 5'd0);
    assign q_empty      = (count_q == '0);
    assign head_valid   = !q_empty && valid_q[head_q];
    assign head_blocked = head_valid && p_active;
    // A killed head is retired without a GRF write, even while P is writing.
    assign pop          = !Reset && !q_empty && !head_blocked;
    assign s_ready      = !Reset && (count_q < CW'(DEPTH));
    // $0 requests complete the handshake but never occupy a slot.
    assign push         = s_valid && s_ready && (s_addr != 5'd0);

    assign q_count = count_q;
    assign p_stall = p_stall_q;

    always_comb begin
        grf_we  = 1'b0;
        grf_a3  = 5'd0;
        grf_wd  = 32'd0;
        grf_pc4 = 32'd0;
        if (!Reset) begin
            if (p_active) begin
                grf_we  = 1'b1;
                grf_a3  = p_addr;
                grf_wd  = p_data;
                grf_pc4 = p_pc4;
            end else if (head_valid) begin
                grf_we  = 1'b1;
                grf_a3  = addr_q[head_q];
                grf_wd  = data_q[head_q];
                grf_pc4 = pc4_q[head_q];
            end
        end
    end

    always_comb begin
        pending = 32'd0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid_q[i]) begin
                pending[addr_q[i]] = 1'b1;
            end
        end
        pending[0] = 1'b0;
    end

    // Payload storage needs no reset: slots are only read while valid.
    always_ff @(posedge Clk) begin
        if (push) begin
            addr_q[tail_q] <= s_addr;
            data_q[tail_q] <= s_data;
            pc4_q[tail_q]  <= s_pc4;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            p_stall_q <= 1'b0;
        end else begin
            // P is younger than every queued entry: drop queued writes it overwrites.
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (p_active && (addr_q[i] == p_addr)) begin
                    valid_q[i] <= 1'b0;
                end
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + AW'(1);
            end
            // Push never targets the head slot while popping, so no ordering conflict.
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end

            if (pop || q_empty) begin
                starve_q  <= '0;
                p_stall_q <= 1'b0;
            end else if (head_blocked) begin
                if (starve_q == SW'(STARVE_LIMIT - 1)) begin
                    p_stall_q <= 1'b1;
                end else begin
                    starve_q <= starve_q + SW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_grf_writeback_arbiter.sv
module tb_grf_writeback_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        Clk;
    logic        Reset;
    logic        p_we;
    logic [4:0]  p_addr;
    logic [31:0] p_data;
    logic [31:0] p_pc4;
    logic        s_valid;
    logic        s_ready;
    logic [4:0]  s_addr;
    logic [31:0] s_data;
    logic [31:0] s_pc4;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc4;
    logic [31:0] pending;
    logic [2:0]  q_count;
    logic        p_stall;

    grf_writeback_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .Clk(Clk), .Reset(Reset),
        .p_we(p_we), .p_addr(p_addr), .p_data(p_data), .p_pc4(p_pc4),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_data(s_data),
        .s_pc4(s_pc4),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc4(grf_pc4),
        .pending(pending), .q_count(q_count), .p_stall(p_stall)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: the queue as a list of requests plus the length of the
    // current head's run of blocked cycles.
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc4;
        bit          live;
    } ent_t;

    ent_t m_q[$];
    int   m_streak;
    int   n_cmp;
    int   n_bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // One clock: drive inputs, check every output against the model, then advance.
    task automatic cycle(input bit r, input bit pw, input logic [4:0] pa, input logic [31:0] pd,
                         input bit sv, input logic [4:0] sa, input logic [31:0] sd);
        logic [31:0] e_wd, e_pc, e_pend;
        logic [4:0]  e_a3;
        bit          e_we, p_act, do_pop, take;
        Reset = r; p_we = pw; p_addr = pa; p_data = pd; p_pc4 = pd ^ 32'h0000_3000;
        s_valid = sv; s_addr = sa; s_data = sd; s_pc4 = sd + 32'h0000_4000;
        #2;
        p_act = pw && (pa != 0);
        e_we = 0; e_a3 = 0; e_wd = 0; e_pc = 0;
        if (!r && p_act) begin
            e_we = 1; e_a3 = pa; e_wd = pd; e_pc = p_pc4;
        end else if (!r && m_q.size() > 0 && m_q[0].live) begin
            e_we = 1; e_a3 = m_q[0].addr; e_wd = m_q[0].data; e_pc = m_q[0].pc4;
        end
        e_pend = 0;
        foreach (m_q[i]) if (m_q[i].live) e_pend[m_q[i].addr] = 1'b1;
        chk("grf_we", {31'd0, grf_we}, {31'd0, e_we});
        chk("grf_a3", {27'd0, grf_a3}, {27'd0, e_a3});
        chk("grf_wd", grf_wd, e_wd);
        chk("grf_pc4", grf_pc4, e_pc);
        chk("s_ready", {31'd0, s_ready}, {31'd0, !r && m_q.size() < DEPTH});
        chk("q_count", {29'd0, q_count}, m_q.size());
        chk("pending", pending, e_pend);
        chk("p_stall", {31'd0, p_stall}, {31'd0, m_streak >= LIMIT});
        @(posedge Clk);
        if (r) begin
            m_q.delete();
            m_streak = 0;
        end else begin
            take = sv && m_q.size() < DEPTH && sa != 0;
            do_pop = m_q.size() > 0 && !(p_act && m_q[0].live);
            if (m_q.size() > 0 && !do_pop) m_streak++;
            else m_streak = 0;
            if (p_act) foreach (m_q[i]) if (m_q[i].addr == pa) m_q[i].live = 0;
            if (do_pop) void'(m_q.pop_front());
            if (take) m_q.push_back('{addr: sa, data: sd, pc4: sd + 32'h0000_4000, live: 1});
        end
        #1;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; m_streak = 0;
        Reset = 1; p_we = 0; p_addr = 0; p_data = 0; p_pc4 = 0;
        s_valid = 0; s_addr = 0; s_data = 0; s_pc4 = 0;
        repeat (2) @(posedge Clk);
        #1;
        cycle(1, 0, 0, 0, 0, 0, 0);
        chk("reset_count", {29'd0, q_count}, 0);

        // Late result to $5, written the following cycle.
        cycle(0, 0, 0, 0, 1, 5, 32'h11);
        chk("s5_pending", pending, 32'h20);
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("s5_drained", pending, 0);

        // P wins over a queued $7; $7 follows on the next free cycle.
        cycle(0, 0, 0, 0, 1, 7, 32'h77);
        cycle(0, 1, 3, 32'hAA, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);

        // Fill the queue under continuous P traffic, then starve the head.
        for (int i = 1; i <= 4; i++) cycle(0, 1, 20, 32'h100 + i, 1, 5'(i), 32'h200 + i);
        chk("fill_count", {29'd0, q_count}, 4);
        chk("fill_ready", {31'd0, s_ready}, 0);
        for (int i = 0; i < 7; i++) cycle(0, 1, 21, 32'h300 + i, (i == 0), 5, 32'h5);
        chk("starve_stall", {31'd0, p_stall}, 1);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 0, 0);

        // WAW kill: P to $9 supersedes the queued $9.
        cycle(0, 0, 0, 0, 1, 9, 32'h1);
        cycle(0, 1, 9, 32'h2, 0, 0, 0);
        chk("kill_pending", pending, 0);
        for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0, 0, 0, 0);

        // $0 request: handshake only.
        cycle(0, 0, 0, 0, 1, 0, 32'hDEAD);
        chk("zero_count", {29'd0, q_count}, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);

        // Reset with three entries queued.
        for (int i = 0; i < 3; i++) cycle(0, 1, 30, 32'h400, 1, 5'(10 + i), 32'h500 + i);
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic with a small register range to force collisions.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 99) < 55),
                  5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 99) < 50), 5'($urandom_range(0, 7)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
